systolic_output_drain: RTL and testbench

// - Downstream of the 14x14 sparse systolic array: snapshots all 196 INT32 PE accumulators on start,

---
 rtl/systolic_pkg.sv | 31 +++
 rtl/requant_lane.sv | 41 ++++
 rtl/systolic_output_drain.sv | 124 ++++++++++++
 tb/tb_systolic_output_drain.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared constants, drain FSM states and INT8 saturation for the output drain
package systolic_pkg;

  localparam int N_ROWS  = 14;
  localparam int N_COLS  = 14;
  localparam int ACC_W   = 32;
  localparam int OUT_W   = 8;
  localparam int SCALE_W = 16;
  localparam int SHIFT_W = 5;
  localparam int ROW_W   = $clog2(N_ROWS);
  localparam int PROD_W  = ACC_W + SCALE_W + 1;
  // One extra bit over the product so the rounding add cannot wrap.
  localparam int SUM_W   = ACC_W + SCALE_W + 2;

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N_ROWS - 1);
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'(2**(OUT_W-1) - 1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(-(2**(OUT_W-1)));

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_FINISH
  } drain_state_e;

  function automatic logic signed [OUT_W-1:0] sat_int8(input logic signed [SUM_W-1:0] v);
    if (v > SAT_MAX) return SAT_MAX[OUT_W-1:0];
    if (v < SAT_MIN) return SAT_MIN[OUT_W-1:0];
    return v[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/requant_lane.sv
// rtl/requant_lane.sv - one output column: S1 multiply, S2 round/shift/saturate/ReLU
module requant_lane
  import systolic_pkg::*;
(
  input  logic               clk,
  input  logic               en_i,
  input  logic [ACC_W-1:0]   acc_i,
  input  logic [SCALE_W-1:0] scale_i,
  input  logic [SHIFT_W-1:0] shift_i,
  input  logic               relu_i,
  output logic [OUT_W-1:0]   res_o
);

  logic signed [PROD_W-1:0] prod_d, prod_q;
  logic signed [SUM_W-1:0]  sum_ext, rnd, shifted;
  logic signed [OUT_W-1:0]  sat_v;
  logic        [OUT_W-1:0]  res_d, res_q;

  // Scale is unsigned: zero-extend it so the signed multiply treats it as positive.
  assign prod_d = $signed({{(PROD_W-ACC_W){acc_i[ACC_W-1]}}, acc_i})
                * $signed({{(PROD_W-SCALE_W){1'b0}}, scale_i});

  always_comb begin
    sum_ext = {prod_q[PROD_W-1], prod_q};
    rnd     = '0;
    if (shift_i != '0) rnd = SUM_W'(1) << (shift_i - SHIFT_W'(1));
    shifted = (sum_ext + rnd) >>> shift_i;
    sat_v   = sat_int8(shifted);
    res_d   = (relu_i && sat_v[OUT_W-1]) ? '0 : sat_v;
  end

  always_ff @(posedge clk) begin
    if (en_i) begin
      prod_q <= prod_d;
      res_q  <= res_d;
    end
  end

  assign res_o = res_q;

endmodule

// File: rtl/systolic_output_drain.sv
// rtl/systolic_output_drain.sv - snapshot 14x14 accumulators, requantize and stream one INT8 row per beat
module systolic_output_drain
  import systolic_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [N_ROWS*N_COLS*ACC_W-1:0]  c_in_flat,
  input  logic [SCALE_W-1:0]              scale,
  input  logic [SHIFT_W-1:0]              shift,
  input  logic                            relu_en,
  output logic                            acc_clr,
  output logic                            busy,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [N_COLS*OUT_W-1:0]         out_data,
  output logic [ROW_W-1:0]                out_row,
  output logic                            out_last,
  output logic                            done
);

  drain_state_e         state_q;
  logic [ACC_W-1:0]     snap_q [N_ROWS][N_COLS];
  logic [SCALE_W-1:0]   scale_q;
  logic [SHIFT_W-1:0]   shift_q;
  logic                 relu_q;
  logic [ROW_W-1:0]     issue_cnt_q;
  logic                 issue_done_q;
  logic                 v1_q, v2_q;
  logic [ROW_W-1:0]     row1_q, row2_q;
  logic                 acc_clr_q, busy_q, done_q;
  logic                 out_valid_q, out_last_q;
  logic [ROW_W-1:0]     out_row_q;
  logic [N_COLS*OUT_W-1:0] out_data_q;
  logic [OUT_W-1:0]     lane_res [N_COLS];
  logic                 adv, issue;

  // Every stage moves together; a stalled output freezes the whole pipe.
  assign adv   = !out_valid_q || out_ready;
  assign issue = (state_q == ST_DRAIN) && !issue_done_q;

  for (genvar c = 0; c < N_COLS; c++) begin : g_lane
    requant_lane u_lane (
      .clk     (clk),
      .en_i    (adv),
      .acc_i   (snap_q[issue_cnt_q][c]),
      .scale_i (scale_q),
      .shift_i (shift_q),
      .relu_i  (relu_q),
      .res_o   (lane_res[c])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      issue_cnt_q  <= '0;
      issue_done_q <= 1'b0;
      v1_q         <= 1'b0;
      v2_q         <= 1'b0;
      row1_q       <= '0;
      row2_q       <= '0;
      acc_clr_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_row_q    <= '0;
      out_data_q   <= '0;
    end else begin
      acc_clr_q <= 1'b0;
      done_q    <= 1'b0;
      if (adv) begin
        v1_q        <= issue;
        row1_q      <= issue_cnt_q;
        v2_q        <= v1_q;
        row2_q      <= row1_q;
        out_valid_q <= v2_q;
        out_row_q   <= row2_q;
        out_last_q  <= v2_q && (row2_q == LAST_ROW);
        for (int c = 0; c < N_COLS; c++) out_data_q[c*OUT_W +: OUT_W] <= lane_res[c];
        if (issue) begin
          if (issue_cnt_q == LAST_ROW) issue_done_q <= 1'b1;
          else                         issue_cnt_q  <= issue_cnt_q + ROW_W'(1);
        end
      end
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            for (int r = 0; r < N_ROWS; r++)
              for (int c = 0; c < N_COLS; c++)
                snap_q[r][c] <= c_in_flat[(r*N_COLS+c)*ACC_W +: ACC_W];
            scale_q      <= scale;
            shift_q      <= shift;
            relu_q       <= relu_en;
            issue_cnt_q  <= '0;
            issue_done_q <= 1'b0;
            acc_clr_q    <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (out_valid_q && out_ready && out_last_q) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_FINISH;
          end
        end
        ST_FINISH: state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  assign acc_clr   = acc_clr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_row   = out_row_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_systolic_output_drain.sv
// tb/tb_systolic_output_drain.sv - directed vector bench for systolic_output_drain
module tb_systolic_output_drain;
  import systolic_pkg::*;

  logic                           clk;
  logic                           rst;
  logic                           start;
  logic [N_ROWS*N_COLS*ACC_W-1:0] c_in_flat;
  logic [SCALE_W-1:0]             scale;
  logic [SHIFT_W-1:0]             shift;
  logic                           relu_en;
  logic                           acc_clr;
  logic                           busy;
  logic                           out_valid;
  logic                           out_ready;
  logic [N_COLS*OUT_W-1:0]        out_data;
  logic [ROW_W-1:0]               out_row;
  logic                           out_last;
  logic                           done;

  systolic_output_drain dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .c_in_flat (c_in_flat),
    .scale     (scale),
    .shift     (shift),
    .relu_en   (relu_en),
    .acc_clr   (acc_clr),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_last  (out_last),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [ACC_W-1:0]   acc;
    logic [SCALE_W-1:0] scl;
    logic [SHIFT_W-1:0] shf;
    logic               relu;
    logic [OUT_W-1:0]   exp;
  } vec_t;

  vec_t vecs [14];
  logic [N_COLS*OUT_W-1:0] exp_rows [N_ROWS];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic set_ramp();
    for (int r = 0; r < N_ROWS; r++)
      for (int c = 0; c < N_COLS; c++) begin
        c_in_flat[(r*N_COLS+c)*ACC_W +: ACC_W] = ACC_W'(r*16 + c);
        exp_rows[r][c*OUT_W +: OUT_W] = (r*16 + c > 127) ? 8'd127 : OUT_W'(r*16 + c);
      end
    scale = 16'd1; shift = 5'd0; relu_en = 1'b0;
  endtask

  task automatic run_tile(input bit rand_rdy, input bit restart_mid, input int abort_row);
    int  beats = 0;
    int  clr_seen = 1;
    int  first_v = -1;
    int  done_early = 0;
    bit  fin = 0;
    bit  aborted = 0;
    bit  stalled = 0;
    bit  restarted = 0;
    logic [N_COLS*OUT_W-1:0] held_d;
    logic [ROW_W-1:0]        held_r;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    c_in_flat = {(N_ROWS*N_COLS){32'h5A5A_0F0F}};
    scale = 16'h1234; shift = 5'd7; relu_en = ~relu_en;
    chk("acc_clr_pulse", 128'(acc_clr), 128'(1));
    chk("busy_rise", 128'(busy), 128'(1));
    for (int cyc = 0; cyc < 400 && !fin && !aborted; cyc++) begin
      start = 1'b0;
      if (cyc > 0 && acc_clr) clr_seen++;
      if (done) done_early++;
      if (out_valid && first_v < 0) first_v = cyc;
      if (stalled) begin
        chk("stall_valid", 128'(out_valid), 128'(1));
        chk("stall_data", 128'(out_data), 128'(held_d));
        chk("stall_row", 128'(out_row), 128'(held_r));
      end
      out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (restart_mid && !restarted && beats == 4) begin
        start = 1'b1;
        restarted = 1;
      end
      stalled = out_valid && !out_ready;
      held_d  = out_data;
      held_r  = out_row;
      if (out_valid && out_ready) begin
        if (beats < N_ROWS) begin
          chk("beat_row", 128'(out_row), 128'(beats));
          chk("beat_data", 128'(out_data), 128'(exp_rows[beats]));
          chk("beat_last", 128'(out_last), 128'(beats == N_ROWS - 1));
        end else begin
          chk("extra_beat", 128'(beats), 128'(N_ROWS - 1));
        end
        if (out_last) fin = 1;
        if (int'(out_row) == abort_row) aborted = 1;
        beats++;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    if (aborted) begin
      rst = 1'b1;
      @(posedge clk); #1;
      chk("abort_valid", 128'(out_valid), 128'(0));
      chk("abort_busy", 128'(busy), 128'(0));
      chk("abort_done", 128'(done), 128'(0));
      rst = 1'b0;
      @(posedge clk); #1;
      chk("abort_done2", 128'(done), 128'(0));
      return;
    end
    if (!fin) begin
      chk("drain_timeout", 128'(0), 128'(1));
      return;
    end
    chk("done_pulse", 128'(done), 128'(1));
    chk("busy_fall", 128'(busy), 128'(0));
    chk("valid_after", 128'(out_valid), 128'(0));
    chk("beat_count", 128'(beats), 128'(N_ROWS));
    chk("acc_clr_once", 128'(clr_seen), 128'(1));
    chk("done_early", 128'(done_early), 128'(0));
    chk("first_valid_lat", 128'(first_v), 128'(3));
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("finish_start_clr", 128'(acc_clr), 128'(0));
    chk("finish_start_busy", 128'(busy), 128'(0));
    chk("done_single", 128'(done), 128'(0));
  endtask

  initial begin
    vecs[0]  = '{32'd1000,       16'd1,     5'd3,  1'b0, 8'h7D};
    vecs[1]  = '{32'd1100,       16'd1,     5'd3,  1'b0, 8'h7F};
    vecs[2]  = '{32'hFFFF_FC18,  16'd1,     5'd3,  1'b0, 8'h83};
    vecs[3]  = '{32'hFFFF_FC18,  16'd1,     5'd3,  1'b1, 8'h00};
    vecs[4]  = '{32'hFFFB_6C20,  16'd3,     5'd10, 1'b0, 8'h80};
    vecs[5]  = '{32'd7,          16'd40000, 5'd16, 1'b0, 8'h04};
    vecs[6]  = '{32'd12,         16'd1,     5'd3,  1'b0, 8'h02};
    vecs[7]  = '{32'hFFFF_FFF4,  16'd1,     5'd3,  1'b0, 8'hFF};
    vecs[8]  = '{32'd200,        16'd1,     5'd0,  1'b1, 8'h7F};
    vecs[9]  = '{32'hFFFF_FF7F,  16'd1,     5'd0,  1'b0, 8'h80};
    vecs[10] = '{32'h7FFF_FFFF,  16'hFFFF,  5'd31, 1'b0, 8'h7F};
    vecs[11] = '{32'h8000_0000,  16'hFFFF,  5'd31, 1'b0, 8'h80};
    vecs[12] = '{32'd100,        16'd1,     5'd0,  1'b0, 8'h64};
    vecs[13] = '{32'hFFFF_FFFB,  16'd3,     5'd1,  1'b0, 8'hF9};

    rst = 1'b1; start = 1'b0; out_ready = 1'b0;
    c_in_flat = '0; scale = '0; shift = '0; relu_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_acc_clr", 128'(acc_clr), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_valid", 128'(out_valid), 128'(0));
    chk("rst_data", 128'(out_data), 128'(0));
    chk("rst_row", 128'(out_row), 128'(0));
    chk("rst_last", 128'(out_last), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    set_ramp();
    run_tile(1'b0, 1'b0, -1);

    for (int i = 0; i < 14; i++) begin
      c_in_flat = {(N_ROWS*N_COLS){vecs[i].acc}};
      scale     = vecs[i].scl;
      shift     = vecs[i].shf;
      relu_en   = vecs[i].relu;
      for (int r = 0; r < N_ROWS; r++) exp_rows[r] = {N_COLS{vecs[i].exp}};
      run_tile(1'b0, 1'b0, -1);
    end

    set_ramp();
    run_tile(1'b1, 1'b0, -1);

    set_ramp();
    run_tile(1'b0, 1'b1, -1);

    set_ramp();
    run_tile(1'b1, 1'b0, 5);

    set_ramp();
    run_tile(1'b0, 1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
